// File: rtl/ram_access_arbiter_pkg.sv
// ram_access_arbiter_pkg
//   Shared constants and types for the RAM access arbiter.
//   DEF_*       : default sizing for requester count and RAM geometry.
//   grant_tag_t : registered record of a read grant, used one cycle later to
//                 route RAM read data back to its requester.
package ram_access_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_DATA_W  = 8;

  // Wide enough for the largest supported requester count (8).
  localparam int OWNER_W = 3;

  typedef struct packed {
    logic               vld;    // a read was granted last cycle
    logic [OWNER_W-1:0] owner;  // requester index that gets the data
    logic               port;   // 0 = RAM port 1, 1 = RAM port 2
  } grant_tag_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Finds the first set bit of req at or after index start, searching upward
//   and wrapping at N.
//   req   : candidate mask
//   start : first index to examine
//   found : some bit of req is set
//   idx   : index of the selected bit (0 when nothing found)
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(start) + k) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
//   Round-robin arbiter sharing a dual-port RAM between NUM_REQ requesters.
//   Up to two requests are granted per cycle: port 1 takes the first valid
//   requester at/after rr_ptr, port 2 the next one that does not hit the same
//   address as port 1 with a write involved. Read data comes back one cycle
//   after the grant on the requester's rsp slice.
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   req_valid/write/addr/wdata, req_ready : requester side (flattened slices)
//   rsp_valid, rsp_data    : read responses, one cycle after grant
//   ram_*_1 / ram_*_2      : RAM port controls and registered read data
//   collision_count        : saturating count of cycles with a conflict skip
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0]         ram_address_1,
  output logic [ADDR_W-1:0]         ram_address_2,
  output logic [DATA_W-1:0]         ram_write_data_1,
  output logic [DATA_W-1:0]         ram_write_data_2,
  output logic                      ram_write_enable_1,
  output logic                      ram_write_enable_2,
  input  logic [DATA_W-1:0]         ram_read_data_1,
  input  logic [DATA_W-1:0]         ram_read_data_2,
  output logic [15:0]               collision_count
);

  localparam int IW = $clog2(NUM_REQ);

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] rsp_a;

  assign addr_a   = req_addr;
  assign wdata_a  = req_wdata;
  assign rsp_data = rsp_a;

  logic [IW-1:0]      rr_ptr;
  logic               p1_found, p2_found, p1_go, p2_go;
  logic [IW-1:0]      p1_idx, p2_idx;
  logic [NUM_REQ-1:0] conflict, p1_oh, p2_oh, p2_cand;
  grant_tag_t         tag [2];

  rr_pick #(.N(NUM_REQ)) u_pick1 (
    .req   (req_valid),
    .start (rr_ptr),
    .found (p1_found),
    .idx   (p1_idx)
  );

  // A requester clashes with the port-1 winner when it targets the same
  // address and either side writes; two reads of one address are harmless.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_conf
    assign conflict[i] = req_valid[i] && p1_found && (IW'(i) != p1_idx) &&
                         (addr_a[i] == addr_a[p1_idx]) &&
                         (req_write[i] || req_write[p1_idx]);
  end

  assign p1_oh = p1_found ? (NUM_REQ'(1) << p1_idx) : '0;

  // Everything between rr_ptr and the port-1 winner is idle by construction,
  // so searching upward from the winner only ever reaches requesters that
  // lie before rr_ptr on the wrap.
  assign p2_cand = req_valid & ~conflict & ~p1_oh;

  rr_pick #(.N(NUM_REQ)) u_pick2 (
    .req   (p2_cand),
    .start (inc_wrap(p1_idx)),
    .found (p2_found),
    .idx   (p2_idx)
  );

  assign p1_go = p1_found && !reset;
  assign p2_go = p2_found && !reset;
  assign p2_oh = p2_go ? (NUM_REQ'(1) << p2_idx) : '0;

  assign req_ready = p1_go ? (p1_oh | p2_oh) : '0;

  always_comb begin
    ram_address_1      = '0;
    ram_write_data_1   = '0;
    ram_write_enable_1 = 1'b0;
    ram_address_2      = '0;
    ram_write_data_2   = '0;
    ram_write_enable_2 = 1'b0;
    if (p1_go) begin
      ram_address_1      = addr_a[p1_idx];
      ram_write_enable_1 = req_write[p1_idx];
      ram_write_data_1   = req_write[p1_idx] ? wdata_a[p1_idx] : '0;
    end
    if (p2_go) begin
      ram_address_2      = addr_a[p2_idx];
      ram_write_enable_2 = req_write[p2_idx];
      ram_write_data_2   = req_write[p2_idx] ? wdata_a[p2_idx] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr          <= '0;
      collision_count <= '0;
      tag[0]          <= '0;
      tag[1]          <= '0;
    end else begin
      if (p2_go)      rr_ptr <= inc_wrap(p2_idx);
      else if (p1_go) rr_ptr <= inc_wrap(p1_idx);
      if (|conflict && collision_count != 16'hFFFF)
        collision_count <= collision_count + 16'd1;
      tag[0] <= '{vld: p1_go && !req_write[p1_idx], owner: OWNER_W'(p1_idx), port: 1'b0};
      tag[1] <= '{vld: p2_go && !req_write[p2_idx], owner: OWNER_W'(p2_idx), port: 1'b1};
    end
  end

  // Route registered RAM read data to the tagged owner. Gating on reset drops
  // a response whose grant landed just before reset.
  always_comb begin
    rsp_valid = '0;
    rsp_a     = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!reset && tag[p].vld && tag[p].owner == OWNER_W'(i)) begin
          rsp_valid[i] = 1'b1;
          rsp_a[i]     = tag[p].port ? ram_read_data_2 : ram_read_data_1;
        end
      end
    end
  end

endmodule
